ula_exec_stage: RTL and testbench

- Execute stage wrapped around the combinational ula: holds the architectural register bank and issues operands, op and register reads to the ula.
- Captures the ula result and writes it back to the destination register.
- Two-stage pipeline (ISSUE -> EX/WB) with a valid/ready handshake upstream, a stall input downstream, EX->ISSUE forwarding and a retired-instruction counter.
- Sits between the decoder (upstream) and the ula (downstream/loop-back).

---
 rtl/ula_exec_stage_pkg.sv | 17 +
 rtl/ula_reg_bank.sv | 55 +++++
 rtl/ula_exec_stage.sv | 152 +++++++++++++++
 tb/tb_ula_exec_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_exec_stage_pkg.sv
// ---------------------------------------------------------------------------
// ula_exec_stage_pkg
//   Shared constants for the ula execute stage and its register bank.
//   DEF_* values are the default parameter values of the stage. REG_ZERO is
//   the value every architectural register takes on reset.
// ---------------------------------------------------------------------------
package ula_exec_stage_pkg;

  localparam int DEF_BITS  = 8;                  // datapath width
  localparam int DEF_OP    = 8;                  // opcode width
  localparam int DEF_NREGS = 4;                  // architectural registers
  localparam int DEF_REG_W = $clog2(DEF_NREGS);  // register index width
  localparam int DEF_CNT_W = 16;                 // retired-counter width

  localparam logic [DEF_BITS-1:0] REG_ZERO = '0;

endpackage : ula_exec_stage_pkg

// File: rtl/ula_reg_bank.sv
// ---------------------------------------------------------------------------
// ula_reg_bank
//   NREGS x BITS architectural register bank for the ula execute stage.
//   Two combinational operand read ports, one combinational debug read port
//   and a single synchronous write port. Synchronous, active-high clear.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high clear of every register
//   i_rd_a_sel  operand-a register index   -> o_rd_a_data
//   i_rd_b_sel  operand-b register index   -> o_rd_b_data
//   i_dbg_sel   debug register index       -> o_dbg_data
//   i_wr_en     write strobe (ignored while i_rst is high)
//   i_wr_sel    write register index
//   i_wr_data   write value
// ---------------------------------------------------------------------------
module ula_reg_bank
  import ula_exec_stage_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int NREGS = DEF_NREGS,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_rd_a_sel,
  output logic [BITS-1:0]  o_rd_a_data,
  input  logic [REG_W-1:0] i_rd_b_sel,
  output logic [BITS-1:0]  o_rd_b_data,
  input  logic [REG_W-1:0] i_dbg_sel,
  output logic [BITS-1:0]  o_dbg_data,
  input  logic             i_wr_en,
  input  logic [REG_W-1:0] i_wr_sel,
  input  logic [BITS-1:0]  i_wr_data
);

  logic [BITS-1:0] r_regs [NREGS];

  // NOTE: this bank is a handful of flops, not a RAM macro, so it is cleared
  // in reset; the debug port and the first operand reads must see zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= REG_ZERO;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_sel] <= i_wr_data;
    end
  end

  assign o_rd_a_data = r_regs[i_rd_a_sel];
  assign o_rd_b_data = r_regs[i_rd_b_sel];
  assign o_dbg_data  = r_regs[i_dbg_sel];

endmodule : ula_reg_bank

// File: rtl/ula_exec_stage.sv
// ---------------------------------------------------------------------------
// ula_exec_stage
//   Two-stage execute wrapper (ISSUE -> EX/WB) around a combinational ula.
//   ISSUE reads the register bank (with EX->ISSUE forwarding) and registers
//   operands and opcode onto the ula_*_out ports. EX/WB captures the ula
//   result on the next edge, writes it to the destination register, pulses
//   wb_valid_out and bumps the retired counter. stall_in freezes EX.
//
// Ports
//   clk_in, rst_in       clock (rising) / synchronous active-high reset
//   instr_valid_in       upstream instruction valid
//   instr_ready_out      stage can accept (= ~stall_in)
//   op_in                opcode, forwarded to the ula unchanged
//   ra_in                destination and operand-a register
//   rb_in                operand-b register
//   stall_in             downstream freeze request
//   ula_a_out/b/op_out   registered ula operands and opcode
//   ula_result_in        combinational ula result
//   wb_valid_out         one-cycle writeback strobe
//   wb_reg_out/data_out  last register written and value
//   retired_out          completed writebacks, wraps modulo 2^CNT_W
//   dbg_sel_in           debug register select -> dbg_data_out
// ---------------------------------------------------------------------------
module ula_exec_stage
  import ula_exec_stage_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int OP    = DEF_OP,
  parameter int NREGS = DEF_NREGS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             instr_valid_in,
  output logic             instr_ready_out,
  input  logic [OP-1:0]    op_in,
  input  logic [REG_W-1:0] ra_in,
  input  logic [REG_W-1:0] rb_in,
  input  logic             stall_in,
  output logic [BITS-1:0]  ula_a_out,
  output logic [BITS-1:0]  ula_b_out,
  output logic [OP-1:0]    ula_op_out,
  input  logic [BITS-1:0]  ula_result_in,
  output logic             wb_valid_out,
  output logic [REG_W-1:0] wb_reg_out,
  output logic [BITS-1:0]  wb_data_out,
  output logic [CNT_W-1:0] retired_out,
  input  logic [REG_W-1:0] dbg_sel_in,
  output logic [BITS-1:0]  dbg_data_out
);

  // EX stage state
  logic             r_ex_valid;
  logic [REG_W-1:0] r_ex_rd;
  logic [BITS-1:0]  r_ula_a;
  logic [BITS-1:0]  r_ula_b;
  logic [OP-1:0]    r_ula_op;

  // Writeback / status state
  logic             r_wb_valid;
  logic [REG_W-1:0] r_wb_reg;
  logic [BITS-1:0]  r_wb_data;
  logic [CNT_W-1:0] r_retired;

  logic             w_accept;
  logic             w_retire;
  logic [BITS-1:0]  w_bank_a;
  logic [BITS-1:0]  w_bank_b;
  logic [BITS-1:0]  w_opnd_a;
  logic [BITS-1:0]  w_opnd_b;

  // A stall freezes EX, so the stage can only take a new instruction when
  // EX is guaranteed to drain (or is empty) at the same edge.
  assign instr_ready_out = ~stall_in;
  assign w_accept        = instr_valid_in & ~stall_in;
  assign w_retire        = r_ex_valid & ~stall_in;

  ula_reg_bank #(
    .BITS  (BITS),
    .NREGS (NREGS),
    .REG_W (REG_W)
  ) u_reg_bank (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_rd_a_sel  (ra_in),
    .o_rd_a_data (w_bank_a),
    .i_rd_b_sel  (rb_in),
    .o_rd_b_data (w_bank_b),
    .i_dbg_sel   (dbg_sel_in),
    .o_dbg_data  (dbg_data_out),
    .i_wr_en     (w_retire & ~rst_in),
    .i_wr_sel    (r_ex_rd),
    .i_wr_data   (ula_result_in)
  );

  // EX->ISSUE forwarding: the bank is only written at the retiring edge, so
  // an instruction issued at that same edge must take the ula result directly.
  // NOTE: every signal driven here gets a value on every path (default first),
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    w_opnd_a = w_bank_a;
    w_opnd_b = w_bank_b;
    if (w_retire && (r_ex_rd == ra_in)) w_opnd_a = ula_result_in;
    if (w_retire && (r_ex_rd == rb_in)) w_opnd_b = ula_result_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ex_valid <= 1'b0;
      r_ex_rd    <= '0;
      r_ula_a    <= '0;
      r_ula_b    <= '0;
      r_ula_op   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_data  <= '0;
      r_retired  <= '0;
    end else begin
      r_wb_valid <= w_retire;

      if (w_retire) begin
        r_wb_reg  <= r_ex_rd;
        r_wb_data <= ula_result_in;
        r_retired <= r_retired + CNT_W'(1);
      end

      // Accept wins over drain so back-to-back issue keeps EX occupied.
      // While stalled neither branch fires and EX holds.
      if (w_accept) begin
        r_ex_valid <= 1'b1;
        r_ex_rd    <= ra_in;
        r_ula_a    <= w_opnd_a;
        r_ula_b    <= w_opnd_b;
        r_ula_op   <= op_in;
      end else if (w_retire) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ula_a_out    = r_ula_a;
  assign ula_b_out    = r_ula_b;
  assign ula_op_out   = r_ula_op;
  assign wb_valid_out = r_wb_valid;
  assign wb_reg_out   = r_wb_reg;
  assign wb_data_out  = r_wb_data;
  assign retired_out  = r_retired;

endmodule : ula_exec_stage

// File: tb/tb_ula_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_ula_exec_stage
//   Directed bench for ula_exec_stage. A small behavioural ula closes the
//   loop: op 0x00 = NOT b, op 0x01 = a + b, otherwise a ^ b.
//   CNT_W is set to 4 so the retired counter wraps quickly.
// ---------------------------------------------------------------------------
module tb_ula_exec_stage;

  localparam int BITS  = 8;
  localparam int OP    = 8;
  localparam int NREGS = 4;
  localparam int REG_W = 2;
  localparam int CNT_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             instr_valid_in;
  logic             instr_ready_out;
  logic [OP-1:0]    op_in;
  logic [REG_W-1:0] ra_in;
  logic [REG_W-1:0] rb_in;
  logic             stall_in;
  logic [BITS-1:0]  ula_a_out;
  logic [BITS-1:0]  ula_b_out;
  logic [OP-1:0]    ula_op_out;
  logic [BITS-1:0]  ula_result_in;
  logic             wb_valid_out;
  logic [REG_W-1:0] wb_reg_out;
  logic [BITS-1:0]  wb_data_out;
  logic [CNT_W-1:0] retired_out;
  logic [REG_W-1:0] dbg_sel_in;
  logic [BITS-1:0]  dbg_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  always_comb begin
    case (ula_op_out)
      8'h00:   ula_result_in = ~ula_b_out;
      8'h01:   ula_result_in = ula_a_out + ula_b_out;
      default: ula_result_in = ula_a_out ^ ula_b_out;
    endcase
  end

  ula_exec_stage #(
    .BITS  (BITS),
    .OP    (OP),
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .op_in           (op_in),
    .ra_in           (ra_in),
    .rb_in           (rb_in),
    .stall_in        (stall_in),
    .ula_a_out       (ula_a_out),
    .ula_b_out       (ula_b_out),
    .ula_op_out      (ula_op_out),
    .ula_result_in   (ula_result_in),
    .wb_valid_out    (wb_valid_out),
    .wb_reg_out      (wb_reg_out),
    .wb_data_out     (wb_data_out),
    .retired_out     (retired_out),
    .dbg_sel_in      (dbg_sel_in),
    .dbg_data_out    (dbg_data_out)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [OP-1:0] op, input logic [REG_W-1:0] ra,
                       input logic [REG_W-1:0] rb);
    instr_valid_in = 1'b1;
    op_in          = op;
    ra_in          = ra;
    rb_in          = rb;
  endtask

  task automatic idle();
    instr_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle();
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    idle();
    stall_in = 1'b0;
    step();
    step();
    checks++; if (ula_a_out !== 8'h00) begin errors++; $display("FAIL reset_ula_a: got %h want 00", ula_a_out); end
    checks++; if (ula_b_out !== 8'h00) begin errors++; $display("FAIL reset_ula_b: got %h want 00", ula_b_out); end
    checks++; if (ula_op_out !== 8'h00) begin errors++; $display("FAIL reset_ula_op: got %h want 00", ula_op_out); end
    checks++; if (wb_valid_out !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_out); end
    checks++; if (wb_data_out !== 8'h00) begin errors++; $display("FAIL reset_wb_data: got %h want 00", wb_data_out); end
    checks++; if (retired_out !== 4'h0) begin errors++; $display("FAIL reset_retired: got %h want 0", retired_out); end
    for (int s = 0; s < NREGS; s++) begin
      dbg_sel_in = REG_W'(s);
      #1;
      checks++; if (dbg_data_out !== 8'h00) begin errors++; $display("FAIL reset_dbg_r%0d: got %h want 00", s, dbg_data_out); end
    end
    rst_in = 1'b0;
  endtask

  // Starts from a freshly reset bank.
  task automatic test_single_not();
    drive(8'h00, 2'd0, 2'd1);
    step();
    idle();
    checks++; if (ula_b_out !== 8'h00) begin errors++; $display("FAIL single_ula_b: got %h want 00", ula_b_out); end
    checks++; if (wb_valid_out !== 1'b0) begin errors++; $display("FAIL single_wb_early: got %b want 0", wb_valid_out); end
    step();
    checks++; if (wb_valid_out !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b want 1", wb_valid_out); end
    checks++; if (wb_reg_out !== 2'd0) begin errors++; $display("FAIL single_wb_reg: got %0d want 0", wb_reg_out); end
    checks++; if (wb_data_out !== 8'hFF) begin errors++; $display("FAIL single_wb_data: got %h want ff", wb_data_out); end
    checks++; if (retired_out !== 4'h1) begin errors++; $display("FAIL single_retired: got %h want 1", retired_out); end
    dbg_sel_in = 2'd0;
    #1;
    checks++; if (dbg_data_out !== 8'hFF) begin errors++; $display("FAIL single_dbg_r0: got %h want ff", dbg_data_out); end
    step();
    checks++; if (wb_valid_out !== 1'b0) begin errors++; $display("FAIL single_wb_pulse: got %b want 0", wb_valid_out); end
    checks++; if (wb_data_out !== 8'hFF) begin errors++; $display("FAIL single_wb_hold: got %h want ff", wb_data_out); end
    checks++; if (ula_op_out !== 8'h00 || ula_b_out !== 8'h00) begin errors++; $display("FAIL single_idle_hold: got op %h b %h want 00 00", ula_op_out, ula_b_out); end
    checks++; if (retired_out !== 4'h1) begin errors++; $display("FAIL single_retired_hold: got %h want 1", retired_out); end
  endtask

  task automatic test_forwarding();
    do_reset();
    drive(8'h00, 2'd0, 2'd1);
    step();
    checks++; if (ula_b_out !== 8'h00) begin errors++; $display("FAIL fwd_first_b: got %h want 00", ula_b_out); end
    drive(8'h00, 2'd1, 2'd0);
    step();
    idle();
    checks++; if (ula_b_out !== 8'hFF) begin errors++; $display("FAIL fwd_b_forwarded: got %h want ff", ula_b_out); end
    checks++; if (wb_valid_out !== 1'b1 || wb_reg_out !== 2'd0) begin errors++; $display("FAIL fwd_first_wb: got v %b r %0d want 1 0", wb_valid_out, wb_reg_out); end
    step();
    checks++; if (wb_valid_out !== 1'b1 || wb_reg_out !== 2'd1 || wb_data_out !== 8'h00) begin
      errors++; $display("FAIL fwd_second_wb: got v %b r %0d d %h want 1 1 00", wb_valid_out, wb_reg_out, wb_data_out);
    end
    dbg_sel_in = 2'd1;
    #1;
    checks++; if (dbg_data_out !== 8'h00) begin errors++; $display("FAIL fwd_dbg_r1: got %h want 00", dbg_data_out); end
    checks++; if (retired_out !== 4'h2) begin errors++; $display("FAIL fwd_retired: got %h want 2", retired_out); end
  endtask

  // Bank on entry: r0=ff r1=00 r2=00 r3=00, retired=2, EX empty.
  task automatic test_back_to_back();
    drive(8'h01, 2'd1, 2'd0);  // r1 = 00 + ff = ff
    step();
    checks++; if (ula_a_out !== 8'h00 || ula_b_out !== 8'hFF) begin errors++; $display("FAIL b2b_i1_opnds: got %h %h want 00 ff", ula_a_out, ula_b_out); end
    drive(8'h01, 2'd1, 2'd1);  // r1 = ff + ff = fe, both operands forwarded
    step();
    checks++; if (ula_a_out !== 8'hFF || ula_b_out !== 8'hFF) begin errors++; $display("FAIL b2b_i2_fwd_ab: got %h %h want ff ff", ula_a_out, ula_b_out); end
    checks++; if (wb_reg_out !== 2'd1 || wb_data_out !== 8'hFF) begin errors++; $display("FAIL b2b_i1_wb: got r %0d d %h want 1 ff", wb_reg_out, wb_data_out); end
    drive(8'h01, 2'd2, 2'd1);  // r2 = 00 + fe = fe, b forwarded
    step();
    idle();
    checks++; if (ula_a_out !== 8'h00 || ula_b_out !== 8'hFE) begin errors++; $display("FAIL b2b_i3_fwd_b: got %h %h want 00 fe", ula_a_out, ula_b_out); end
    checks++; if (wb_valid_out !== 1'b1 || wb_data_out !== 8'hFE) begin errors++; $display("FAIL b2b_i2_wb: got v %b d %h want 1 fe", wb_valid_out, wb_data_out); end
    step();
    checks++; if (wb_valid_out !== 1'b1 || wb_reg_out !== 2'd2 || wb_data_out !== 8'hFE) begin
      errors++; $display("FAIL b2b_i3_wb: got v %b r %0d d %h want 1 2 fe", wb_valid_out, wb_reg_out, wb_data_out);
    end
    checks++; if (retired_out !== 4'h5) begin errors++; $display("FAIL b2b_retired: got %h want 5", retired_out); end
  endtask

  // r3=00 on entry, r2=fe, retired=5.
  task automatic test_stall();
    drive(8'h00, 2'd3, 2'd3);  // r3 = ~00 = ff
    step();
    stall_in = 1'b1;
    drive(8'h01, 2'd2, 2'd2);  // must not be accepted while stalled
    #1;
    checks++; if (instr_ready_out !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", instr_ready_out); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (wb_valid_out !== 1'b0) begin errors++; $display("FAIL stall_wb_%0d: got %b want 0", k, wb_valid_out); end
      checks++; if (ula_op_out !== 8'h00 || ula_a_out !== 8'h00 || ula_b_out !== 8'h00) begin
        errors++; $display("FAIL stall_frozen_%0d: got op %h a %h b %h want 00 00 00", k, ula_op_out, ula_a_out, ula_b_out);
      end
      checks++; if (retired_out !== 4'h5) begin errors++; $display("FAIL stall_retired_%0d: got %h want 5", k, retired_out); end
    end
    stall_in = 1'b0;
    idle();
    step();
    checks++; if (wb_valid_out !== 1'b1 || wb_reg_out !== 2'd3 || wb_data_out !== 8'hFF) begin
      errors++; $display("FAIL stall_release_wb: got v %b r %0d d %h want 1 3 ff", wb_valid_out, wb_reg_out, wb_data_out);
    end
    checks++; if (retired_out !== 4'h6) begin errors++; $display("FAIL stall_release_retired: got %h want 6", retired_out); end
    step();
    checks++; if (wb_valid_out !== 1'b0 || retired_out !== 4'h6) begin errors++; $display("FAIL stall_once: got v %b cnt %h want 0 6", wb_valid_out, retired_out); end
    dbg_sel_in = 2'd2;
    #1;
    checks++; if (dbg_data_out !== 8'hFE) begin errors++; $display("FAIL stall_no_accept_r2: got %h want fe", dbg_data_out); end
  endtask

  // r2=fe, r3=ff on entry.
  task automatic test_reset_mid_op();
    drive(8'h00, 2'd2, 2'd3);
    step();
    idle();
    checks++; if (ula_b_out !== 8'hFF) begin errors++; $display("FAIL rmid_accept_b: got %h want ff", ula_b_out); end
    rst_in = 1'b1;
    step();
    checks++; if (wb_valid_out !== 1'b0) begin errors++; $display("FAIL rmid_wb: got %b want 0", wb_valid_out); end
    checks++; if (retired_out !== 4'h0) begin errors++; $display("FAIL rmid_retired: got %h want 0", retired_out); end
    checks++; if (ula_b_out !== 8'h00) begin errors++; $display("FAIL rmid_ula_b: got %h want 00", ula_b_out); end
    dbg_sel_in = 2'd2;
    #1;
    checks++; if (dbg_data_out !== 8'h00) begin errors++; $display("FAIL rmid_r2: got %h want 00", dbg_data_out); end
    rst_in = 1'b0;
    step();
    checks++; if (wb_valid_out !== 1'b0 || retired_out !== 4'h0) begin errors++; $display("FAIL rmid_after: got v %b cnt %h want 0 0", wb_valid_out, retired_out); end
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(8'h00, 2'd0, 2'd0);
      step();
      if (i > 0) begin
        exp_cnt = CNT_W'(i);
        checks++; if (retired_out !== exp_cnt) begin errors++; $display("FAIL wrap_cnt_%0d: got %h want %h", i, retired_out, exp_cnt); end
      end
    end
    idle();
    step();
    checks++; if (retired_out !== 4'h1) begin errors++; $display("FAIL wrap_cnt_17: got %h want 1", retired_out); end
    checks++; if (wb_valid_out !== 1'b1) begin errors++; $display("FAIL wrap_last_wb: got %b want 1", wb_valid_out); end
  endtask

  initial begin
    rst_in         = 1'b1;
    instr_valid_in = 1'b0;
    op_in          = '0;
    ra_in          = '0;
    rb_in          = '0;
    stall_in       = 1'b0;
    dbg_sel_in     = '0;

    test_reset();
    test_single_not();
    test_forwarding();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    test_counter_wrap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ula_exec_stage
